// File: rtl/snf_txdat_lcrd_pkg.sv
// rtl/snf_txdat_lcrd_pkg.sv - shared link-layer definitions for the SNF TX channels
//
// Purpose: link TX state encodings, DAT credit counter sizing, credit step and
// the LCrdReturn flit fill value shared by the SNF link-layer transmitters.
// Ports: none (package).
package snf_txdat_lcrd_pkg;

  localparam int CHIE_DAT_FLIT_WIDTH      = 392;
  localparam int SNF_LL_DAT_CRD_CNT_WIDTH = 4;
  localparam int SNF_LL_DAT_CRD_RANGE     = 15;
  localparam int SNF_LL_CRD_INCDEC_ONE    = 1;

  // An LCrdReturn flit is all zeros (opcode 0); replicated to the flit width.
  localparam logic SNF_LCRD_RETURN_FLIT = 1'b0;

  typedef enum logic [1:0] {
    SNF_LL_TX_STOP   = 2'd0,
    SNF_LL_TX_RUN    = 2'd1,
    SNF_LL_TX_DRAIN  = 2'd2,
    SNF_LL_TX_RETURN = 2'd3
  } snf_ll_tx_state_e;

endpackage

// File: rtl/snf_txdat_lcrd_if.sv
// rtl/snf_txdat_lcrd_if.sv - CHI-E DAT link channel (credit / flit) bundle
//
// Purpose: outbound DAT link signals between transmitter and receiver.
// Signals:
//   txdatlcrdv     receiver -> transmitter  one L-credit granted this cycle
//   txdatflitpend  transmitter -> receiver  flit may follow next cycle
//   txdatflitv     transmitter -> receiver  flit valid
//   txdatflit      transmitter -> receiver  flit payload
// Modports: master = transmitter, slave = receiver.
interface snf_txdat_lcrd_if
  import snf_txdat_lcrd_pkg::*;
#(
  parameter int FLIT_W = CHIE_DAT_FLIT_WIDTH
) ();

  logic              txdatlcrdv;
  logic              txdatflitpend;
  logic              txdatflitv;
  logic [FLIT_W-1:0] txdatflit;

  modport master (input txdatlcrdv, output txdatflitpend, output txdatflitv, output txdatflit);
  modport slave  (output txdatlcrdv, input txdatflitpend, input txdatflitv, input txdatflit);

endinterface

// File: rtl/snf_txdat_lcrd_fifo.sv
// rtl/snf_txdat_lcrd_fifo.sv - small FIFO for outbound link flits
//
// Purpose: DEPTH x W first-in first-out buffer with show-ahead head.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   push, push_data   write strobe (caller gates with ~full) and data
//   pop               read strobe (caller gates with ~empty)
//   head              oldest entry, valid while ~empty
//   count             current occupancy
//   full, empty       occupancy flags
module snf_txdat_lcrd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Payload storage needs no reset; only pointers and occupancy define content.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/snf_txdat_lcrd.sv
// rtl/snf_txdat_lcrd.sv - SNF outbound DAT link transmitter with L-credit consumption
//
// Purpose: buffers DAT flits from the datapath, launches one per held link
// credit, and on deactivation drains the buffer then returns every held credit
// as all-zero LCrdReturn flits.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   run_state           STOP -> RUN request
//   deact_req           RUN -> DRAIN request (wins over run_state)
//   txdat_valid_s0/_flit_s0/_ready_s0   datapath flit handshake
//   lnk                 link channel (master): lcrdv in, flitpend/flitv/flit out
//   txdat_crd_cnt       credits currently held
//   txdat_crd_rtn_done  all credits returned, link in STOP
//   txdat_crd_ovf       sticky: credit granted while already at LCRD_MAX
module snf_txdat_lcrd
  import snf_txdat_lcrd_pkg::*;
#(
  parameter int FLIT_W    = CHIE_DAT_FLIT_WIDTH,
  parameter int LCRD_MAX  = SNF_LL_DAT_CRD_RANGE,
  parameter int CNT_W     = SNF_LL_DAT_CRD_CNT_WIDTH,
  parameter int BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_state,
  input  logic                 deact_req,
  input  logic                 txdat_valid_s0,
  input  logic [FLIT_W-1:0]    txdat_flit_s0,
  output logic                 txdat_ready_s0,
  snf_txdat_lcrd_if.master     lnk,
  output logic [CNT_W-1:0]     txdat_crd_cnt,
  output logic                 txdat_crd_rtn_done,
  output logic                 txdat_crd_ovf
);

  localparam int FCW = $clog2(BUF_DEPTH) + 1;

  snf_ll_tx_state_e  state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              ovf_q, rtn_done_q, flitv_q, pend_q;
  logic [FLIT_W-1:0] flit_q;

  logic              push, launch, lret, inc, dec, at_max, ovf_set, pend_nxt;
  logic [FLIT_W-1:0] fifo_head;
  logic [FCW-1:0]    fifo_count, fifo_cnt_nxt;
  logic              fifo_full, fifo_empty;

  snf_txdat_lcrd_fifo #(.W(FLIT_W), .DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (txdat_flit_s0),
    .pop       (launch),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    txdat_ready_s0 = (state_q == SNF_LL_TX_RUN) && !fifo_full;
    push           = txdat_valid_s0 && txdat_ready_s0;
    // Only data already resident in the buffer can launch, so a flit written
    // this cycle is at the earliest launched next cycle.
    launch  = ((state_q == SNF_LL_TX_RUN) || (state_q == SNF_LL_TX_DRAIN))
              && !fifo_empty && (cnt_q != '0);
    lret    = (state_q == SNF_LL_TX_RETURN) && (cnt_q != '0);
    inc     = lnk.txdatlcrdv;
    dec     = launch || lret;
    at_max  = (cnt_q == CNT_W'(LCRD_MAX));
    ovf_set = inc && !dec && at_max;

    cnt_nxt = cnt_q;
    if (inc && !dec && !at_max)  cnt_nxt = cnt_q + CNT_W'(SNF_LL_CRD_INCDEC_ONE);
    else if (dec && !inc)        cnt_nxt = cnt_q - CNT_W'(SNF_LL_CRD_INCDEC_ONE);

    state_nxt = state_q;
    unique case (state_q)
      SNF_LL_TX_STOP:   if (run_state) state_nxt = SNF_LL_TX_RUN;
      SNF_LL_TX_RUN:    if (deact_req) state_nxt = SNF_LL_TX_DRAIN;
      // An empty buffer means nothing can be launching this cycle; a flit
      // launched earlier already sits in the output register.
      SNF_LL_TX_DRAIN:  if (fifo_empty) state_nxt = SNF_LL_TX_RETURN;
      // A credit arriving now must still be returned, so it holds RETURN.
      SNF_LL_TX_RETURN: if ((cnt_q == '0) && !inc) state_nxt = SNF_LL_TX_STOP;
      default:          state_nxt = SNF_LL_TX_STOP;
    endcase

    // Pending whenever a data flit or an LCrdReturn can go out next cycle.
    fifo_cnt_nxt = fifo_count + FCW'(push) - FCW'(launch);
    pend_nxt     = (fifo_cnt_nxt != '0)
                   || ((state_nxt == SNF_LL_TX_RETURN) && (cnt_nxt != '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SNF_LL_TX_STOP;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      rtn_done_q <= 1'b0;
      flitv_q    <= 1'b0;
      pend_q     <= 1'b0;
      flit_q     <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      pend_q  <= pend_nxt;
      flitv_q <= dec;
      // Idle cycles and LCrdReturn both put the zero flit on the link.
      flit_q  <= launch ? fifo_head : {FLIT_W{SNF_LCRD_RETURN_FLIT}};
      if (ovf_set) ovf_q <= 1'b1;
      if ((state_q == SNF_LL_TX_RETURN) && (state_nxt == SNF_LL_TX_STOP))
        rtn_done_q <= 1'b1;
      else if ((state_q != SNF_LL_TX_RUN) && (state_nxt == SNF_LL_TX_RUN))
        rtn_done_q <= 1'b0;
    end
  end

  assign lnk.txdatflitpend  = pend_q;
  assign lnk.txdatflitv     = flitv_q;
  assign lnk.txdatflit      = flit_q;
  assign txdat_crd_cnt      = cnt_q;
  assign txdat_crd_rtn_done = rtn_done_q;
  assign txdat_crd_ovf      = ovf_q;

endmodule
